// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam int          IM_AW     = 12;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_sel_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bundle: redirect/stall inputs from ID and hazard unit, ROM port, IF/ID outputs.
interface ifu_if #(
  parameter int AW = ifu_pkg::IM_AW
) ();

  logic                  stall;
  ifu_pkg::npc_sel_e     npc_sel;
  logic                  br_taken;
  logic [15:0]           imm16_d;
  logic [25:0]           imm26_d;
  logic [31:0]           jr_target;
  logic [AW-1:0]         im_addr;
  logic [31:0]           im_instr;
  logic [31:0]           pc_f;
  logic                  addr_err_f;
  logic [31:0]           instr_d;
  logic [31:0]           pc_d;
  logic [31:0]           pc8_d;

  modport master (
    input  stall, npc_sel, br_taken, imm16_d, imm26_d, jr_target, im_instr,
    output im_addr, pc_f, addr_err_f, instr_d, pc_d, pc8_d
  );

  modport slave (
    output stall, npc_sel, br_taken, imm16_d, imm26_d, jr_target, im_instr,
    input  im_addr, pc_f, addr_err_f, instr_d, pc_d, pc8_d
  );

endinterface

// File: rtl/ifu_npc.sv
// Combinational next-PC selection; redirect targets are relative to the ID-stage PC.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  npc_sel_e    npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16_d,
  input  logic [25:0] imm26_d,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;

  always_comb begin
    seq_pc = pc_f + 32'd4;
    br_pc  = pc_d + 32'd4 + branch_offset(imm16_d);
    jmp_pc = {pc_d[31:28], imm26_d, 2'b00};
    npc    = seq_pc;
    unique case (npc_sel)
      NPC_SEQ:    npc = seq_pc;
      NPC_BRANCH: npc = br_taken ? br_pc : seq_pc;
      NPC_JUMP:   npc = jmp_pc;
      NPC_JREG:   npc = jr_target;
      default:    npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, ROM address translation, range check and IF/ID register.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET,
  parameter int          AW       = IM_AW
) (
  input  logic clk,
  input  logic reset,
  ifu_if.master bus
);

  localparam logic [31:0] PC_LAST = RESET_PC + 32'((64'd1 << (AW + 2)) - 64'd4);

  logic [31:0] pc_f_q,     pc_f_d;
  logic [31:0] pc_id_q,    pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] npc;
  logic [31:0] pc_off;
  logic        addr_err;

  ifu_npc u_npc (
    .pc_f      (pc_f_q),
    .pc_d      (pc_id_q),
    .npc_sel   (bus.npc_sel),
    .br_taken  (bus.br_taken),
    .imm16_d   (bus.imm16_d),
    .imm26_d   (bus.imm26_d),
    .jr_target (bus.jr_target),
    .npc       (npc)
  );

  always_comb begin
    pc_off   = pc_f_q - RESET_PC;
    addr_err = (pc_f_q[1:0] != 2'b00) || (pc_f_q < RESET_PC) || (pc_f_q > PC_LAST);
  end

  // PC and IF/ID always advance or hold together
  always_comb begin
    pc_f_d     = pc_f_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    if (!bus.stall) begin
      pc_f_d     = npc;
      pc_id_d    = pc_f_q;
      instr_id_d = addr_err ? NOP_INSTR : bus.im_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q     <= RESET_PC;
      pc_id_q    <= 32'd0;
      instr_id_q <= NOP_INSTR;
    end else begin
      pc_f_q     <= pc_f_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
    end
  end

  assign bus.im_addr    = pc_off[AW+1:2];
  assign bus.pc_f       = pc_f_q;
  assign bus.addr_err_f = addr_err;
  assign bus.instr_d    = instr_id_q;
  assign bus.pc_d       = pc_id_q;
  assign bus.pc8_d      = pc_id_q + 32'd8;

endmodule

// File: tb/tb_ifu.sv
// Directed vector bench for ifu: a stepped vector table plus stall and async-reset sequences.
module tb_ifu;
  import ifu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ifu_if bus ();

  ifu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  assign bus.im_instr = 32'hA500_0000 | 32'(bus.im_addr);

  typedef struct {
    npc_sel_e    sel;
    logic        tk;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] jr;
    logic [31:0] e_pcf;
    logic [31:0] e_pcd;
    logic [31:0] e_ins;
    logic [11:0] e_ima;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input npc_sel_e sel, input logic tk, input logic [15:0] i16,
                     input logic [25:0] i26, input logic [31:0] jr,
                     input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                     input logic [31:0] e_ins, input logic [11:0] e_ima, input logic e_err);
    vec_t v;
    v.sel = sel; v.tk = tk; v.i16 = i16; v.i26 = i26; v.jr = jr;
    v.e_pcf = e_pcf; v.e_pcd = e_pcd; v.e_ins = e_ins; v.e_ima = e_ima; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input npc_sel_e sel, input logic tk, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] jr, input logic st);
    bus.npc_sel   = sel;
    bus.br_taken  = tk;
    bus.imm16_d   = i16;
    bus.imm26_d   = i26;
    bus.jr_target = jr;
    bus.stall     = st;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pcf, input logic [31:0] pcd,
                             input logic [31:0] ins, input logic [11:0] ima, input logic err);
    chk({tag, ".pc_f"}, bus.pc_f, pcf);
    chk({tag, ".pc_d"}, bus.pc_d, pcd);
    chk({tag, ".instr_d"}, bus.instr_d, ins);
    chk({tag, ".im_addr"}, 32'(bus.im_addr), 32'(ima));
    chk({tag, ".addr_err_f"}, 32'(bus.addr_err_f), 32'(err));
    chk({tag, ".pc8_d"}, bus.pc8_d, pcd + 32'd8);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);

    // Sequential fetch, taken branch, not-taken branch, jump, jr misaligned, range edges
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3004, 32'h3000, rom(0),  12'h001, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3008, 32'h3004, rom(1),  12'h002, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h300C, 32'h3008, rom(2),  12'h003, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3010, 32'h300C, rom(3),  12'h004, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3014, 32'h3010, rom(4),  12'h005, 0);
    add(NPC_BRANCH, 1, 16'hFFFC, 26'h0,     32'h0,    32'h3004, 32'h3014, rom(5),  12'h001, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3008, 32'h3004, rom(1),  12'h002, 0);
    add(NPC_BRANCH, 0, 16'hFFFC, 26'h0,     32'h0,    32'h300C, 32'h3008, rom(2),  12'h003, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3010, 32'h300C, rom(3),  12'h004, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3014, 32'h3010, rom(4),  12'h005, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3018, 32'h3014, rom(5),  12'h006, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h301C, 32'h3018, rom(6),  12'h007, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3020, 32'h301C, rom(7),  12'h008, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3024, 32'h3020, rom(8),  12'h009, 0);
    add(NPC_JUMP,   0, 16'h0,    26'h0C10,  32'h0,    32'h3040, 32'h3024, rom(9),  12'h010, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3044, 32'h3040, rom(16), 12'h011, 0);
    add(NPC_JREG,   0, 16'h0,    26'h0,     32'h3002, 32'h3002, 32'h3044, rom(17), 12'h000, 1);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3006, 32'h3002, 32'h0,   12'h001, 1);
    add(NPC_JREG,   0, 16'h0,    26'h0,     32'h3000, 32'h3000, 32'h3006, 32'h0,   12'h000, 0);
    add(NPC_SEQ,    0, 16'h0,    26'h0,     32'h0,    32'h3004, 32'h3000, rom(0),  12'h001, 0);
    add(NPC_JREG,   0, 16'h0,    26'h0,     32'h6FFC, 32'h6FFC, 32'h3004, rom(1),  12'hFFF, 0);
    add(NPC_JREG,   0, 16'h0,    26'h0,     32'h7000, 32'h7000, 32'h6FFC, rom(4095), 12'h000, 1);
    add(NPC_JREG,   0, 16'h0,    26'h0,     32'h2FFC, 32'h2FFC, 32'h7000, 32'h0,   12'hFFF, 1);
    add(NPC_JREG,   0, 16'h0,    26'h0,     32'h3000, 32'h3000, 32'h2FFC, 32'h0,   12'h000, 0);

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 32'h3000, 32'h0, 32'h0, 12'h000, 1'b0);
    $display("txn reset: pc_f=%h pc_d=%h instr_d=%h", bus.pc_f, bus.pc_d, bus.instr_d);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].tk, vecs[i].i16, vecs[i].i26, vecs[i].jr, 1'b0);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_pcd,
                  vecs[i].e_ins, vecs[i].e_ima, vecs[i].e_err);
      $display("txn vec%0d: sel=%0d pc_f=%h pc_d=%h instr_d=%h err=%b",
               i, vecs[i].sel, bus.pc_f, bus.pc_d, bus.instr_d, bus.addr_err_f);
    end

    // Stall for 3 edges with a pending jump; target loads on first free edge
    drive(NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_state("pre_stall", 32'h3004, 32'h3000, rom(0), 12'h001, 1'b0);
    drive(NPC_JUMP, 1'b0, 16'h0, 26'h0C10, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_state($sformatf("stall%0d", k), 32'h3004, 32'h3000, rom(0), 12'h001, 1'b0);
      $display("txn stall%0d: pc_f=%h pc_d=%h instr_d=%h", k, bus.pc_f, bus.pc_d, bus.instr_d);
    end
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    check_state("unstall_jump", 32'h3040, 32'h3004, rom(1), 12'h010, 1'b0);
    $display("txn unstall: pc_f=%h pc_d=%h instr_d=%h", bus.pc_f, bus.pc_d, bus.instr_d);

    // Asynchronous reset between edges, while a stall and redirect are presented
    drive(NPC_JREG, 1'b0, 16'h0, 26'h0, 32'h5000, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_state("async_reset", 32'h3000, 32'h0, 32'h0, 12'h000, 1'b0);
    $display("txn async_reset: pc_f=%h pc_d=%h instr_d=%h", bus.pc_f, bus.pc_d, bus.instr_d);
    drive(NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_reset", 32'h3004, 32'h3000, rom(0), 12'h001, 1'b0);
    $display("txn post_reset: pc_f=%h pc_d=%h instr_d=%h", bus.pc_f, bus.pc_d, bus.instr_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
